// File: rtl/conv_result_fifo.sv
// conv_result_fifo: one-frame result buffer between the adder tree and the
// external reader. Words are captured on write commands while idle and
// drained in order under the MEM_READ handshake once a read command arrives.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | accepting write commands; a read command starts a drain
// S_DRAIN | serving MEM_READ requests until the buffer is empty
// S_HOLD  | frame drained; parked while the controller holds 01
module conv_result_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            fifo_command,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  MEM_READ,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  drain_done,
   output logic [1:0]            err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_HOLD  = 2'd2
   } state_e;

   localparam logic [1:0]            CMD_WRITE = 2'b10;
   localparam logic [1:0]            CMD_READ  = 2'b01;
   localparam logic [ADDR_WIDTH:0]   FULL_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]     count_q, count_d;
   logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                    rd_valid_q, rd_valid_d;
   logic                    drain_done_q, drain_done_d;
   logic [1:0]              err_q, err_d;
   logic                    wr_en;
   logic                    full_w, empty_w;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   // Occupancy flags come straight from the registered count.
   assign full_w  = (count_q == FULL_CNT);
   assign empty_w = (count_q == '0);

   // Next-state, pointer and flag decode; the two modes never move count
   // in opposite directions in the same cycle.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      rd_data_d    = rd_data_q;
      rd_valid_d   = 1'b0;
      drain_done_d = 1'b0;
      err_d        = err_q;
      wr_en        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (fifo_command == CMD_WRITE) begin
               if (!full_w) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  count_d  = count_q + CNT_ONE;
               end else begin
                  err_d[0] = 1'b1;
               end
            end else if (fifo_command == CMD_READ) begin
               state_d = S_DRAIN;
            end
            if (MEM_READ) begin
               err_d[1] = 1'b1;
            end
         end

         S_DRAIN: begin
            if (fifo_command == CMD_WRITE) begin
               err_d[0] = 1'b1;
            end
            if (MEM_READ && !empty_w) begin
               rd_data_d  = mem_q[rd_ptr_q];
               rd_valid_d = 1'b1;
               rd_ptr_d   = rd_ptr_q + PTR_ONE;
               count_d    = count_q - CNT_ONE;
               // Last word: done pulse lines up with its rd_valid.
               if (count_q == CNT_ONE) begin
                  state_d      = S_HOLD;
                  drain_done_d = 1'b1;
               end
            end else begin
               if (MEM_READ) begin
                  err_d[1] = 1'b1;
               end
               // Drain of an empty frame finishes straight away.
               if (empty_w) begin
                  state_d      = S_HOLD;
                  drain_done_d = 1'b1;
               end
            end
         end

         S_HOLD: begin
            // Leaving HOLD consumes the command; it is not acted on here.
            if (fifo_command != CMD_READ) begin
               state_d = S_IDLE;
            end
            if (MEM_READ) begin
               err_d[1] = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and output registers; reset discards any stored frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         drain_done_q <= 1'b0;
         err_q        <= 2'b00;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         drain_done_q <= drain_done_d;
         err_q        <= err_d;
      end
   end

   // Storage array; contents are left untouched by reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign full       = full_w;
   assign empty      = empty_w;
   assign count      = count_q;
   assign drain_done = drain_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_conv_result_fifo.sv
// Bench for conv_result_fifo: a queue-based frame model checked against the
// DUT every cycle, plus literal checks on the drained sequences.
module tb_conv_result_fifo;

   localparam int DW = 16;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    fifo_command = 2'b00;
   logic [DW-1:0] wr_data = '0;
   logic          MEM_READ = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          drain_done;
   logic [1:0]    err;

   int checks = 0;
   int errors = 0;

   conv_result_fifo #(.DATA_WIDTH(DW), .DEPTH(256), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .fifo_command(fifo_command), .wr_data(wr_data),
      .MEM_READ(MEM_READ), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
      .empty(empty), .count(count), .drain_done(drain_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the frame is a queue; mode 0 idle, 1 drain, 2 hold.
   logic [DW-1:0] m_q[$];
   int            m_mode = 0;
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_data = '0;
   logic          m_done = 1'b0;
   logic [1:0]    m_err = 2'b00;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_mode  = 0;
         m_valid = 1'b0;
         m_data  = '0;
         m_done  = 1'b0;
         m_err   = 2'b00;
      end else begin
         m_valid = 1'b0;
         m_done  = 1'b0;
         if (MEM_READ && m_mode != 1) m_err[1] = 1'b1;
         if (m_mode == 0) begin
            if (fifo_command == 2'b10) begin
               if (m_q.size() < 256) m_q.push_back(wr_data);
               else m_err[0] = 1'b1;
            end else if (fifo_command == 2'b01) begin
               m_mode = 1;
            end
         end else if (m_mode == 1) begin
            if (fifo_command == 2'b10) m_err[0] = 1'b1;
            if (MEM_READ && m_q.size() > 0) begin
               m_data  = m_q.pop_front();
               m_valid = 1'b1;
            end else if (MEM_READ) begin
               m_err[1] = 1'b1;
            end
            if (m_q.size() == 0) begin
               m_mode = 2;
               m_done = 1'b1;
            end
         end else begin
            if (fifo_command != 2'b01) m_mode = 0;
         end
      end
   end

   // Per-cycle comparison against the model.
   logic chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         chk("count", count, m_q.size());
         chk("empty", empty, m_q.size() == 0);
         chk("full", full, m_q.size() == 256);
         chk("rd_valid", rd_valid, m_valid);
         if (m_valid) chk("rd_data", rd_data, m_data);
         chk("drain_done", drain_done, m_done);
         chk("err", err, m_err);
      end
   end

   // Capture of drained words and done pulses for the literal checks.
   logic [DW-1:0] got[$];
   int            done_cnt = 0;
   logic [DW-1:0] done_word = '0;
   always @(negedge clk) begin
      if (rd_valid) got.push_back(rd_data);
      if (drain_done) begin
         done_cnt++;
         done_word = rd_data;
      end
   end

   // Apply one cycle of inputs, return 1 time unit after the sampling edge.
   task automatic drive(input logic [1:0] c, input logic [DW-1:0] w, input logic m);
      fifo_command = c;
      wr_data      = w;
      MEM_READ     = m;
      @(posedge clk);
      #1;
   endtask

   task automatic drain_n(input int n);
      drive(2'b01, '0, 1'b0);
      for (int i = 0; i < n; i++) drive(2'b01, '0, 1'b1);
      drive(2'b01, '0, 1'b0);
   endtask

   initial begin
      int d0;
      #12 reset = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset count", count, 0);
      chk("reset empty", empty, 1);
      chk("reset err", err, 0);

      // Four single-cycle writes separated by idle cycles.
      for (int i = 1; i <= 4; i++) begin
         drive(2'b10, DW'(i * 16'h0011), 1'b0);
         drive(2'b00, '0, 1'b0);
      end
      chk("t1 count", count, 4);
      chk("t1 full", full, 0);
      chk("t1 err", err, 0);

      // Drain with six requests: four words, then two requests in HOLD.
      got.delete();
      d0 = done_cnt;
      drive(2'b01, '0, 1'b0);
      for (int i = 0; i < 6; i++) drive(2'b01, '0, 1'b1);
      drive(2'b01, '0, 1'b0);
      drive(2'b01, '0, 1'b0);
      chk("t2 nwords", got.size(), 4);
      for (int i = 0; i < got.size() && i < 4; i++) chk("t2 word", got[i], (i + 1) * 16'h0011);
      chk("t2 done pulses", done_cnt - d0, 1);
      chk("t2 done word", done_word, 16'h0044);
      chk("t2 err", err, 2'b10);

      // Fill to 256, overflow by one, drain the whole frame.
      drive(2'b00, '0, 1'b0);
      for (int i = 0; i < 256; i++) drive(2'b10, DW'(i), 1'b0);
      drive(2'b10, 16'hBEEF, 1'b0);
      drive(2'b00, '0, 1'b0);
      chk("t3 full", full, 1);
      chk("t3 count", count, 256);
      chk("t3 err", err, 2'b11);
      got.delete();
      drain_n(256);
      chk("t3 nwords", got.size(), 256);
      for (int i = 0; i < got.size() && i < 256; i++) chk("t3 word", got[i], i);
      chk("t3 count end", count, 0);

      // Pointer wrap: 200 in/out, then 100 more across the wrap point.
      drive(2'b00, '0, 1'b0);
      for (int i = 0; i < 200; i++) drive(2'b10, DW'(i + 7), 1'b0);
      drain_n(200);
      drive(2'b00, '0, 1'b0);
      for (int i = 0; i < 100; i++) drive(2'b10, DW'(1000 + i), 1'b0);
      got.delete();
      drain_n(100);
      chk("t4 nwords", got.size(), 100);
      for (int i = 0; i < got.size() && i < 100; i++) chk("t4 word", got[i], 1000 + i);
      chk("t4 count", count, 0);

      // Held read command: no repeat pulse; re-entry with empty buffer pulses once.
      d0 = done_cnt;
      for (int i = 0; i < 20; i++) drive(2'b01, '0, 1'b0);
      chk("t5 no repeat", done_cnt - d0, 0);
      drive(2'b00, '0, 1'b0);
      drive(2'b01, '0, 1'b0);
      drive(2'b01, '0, 1'b0);
      chk("t5 immediate done", drain_done, 1);
      for (int i = 0; i < 5; i++) drive(2'b01, '0, 1'b0);
      chk("t5 single pulse", done_cnt - d0, 1);

      // Asynchronous reset in the middle of a drain.
      drive(2'b00, '0, 1'b0);
      for (int i = 0; i < 8; i++) drive(2'b10, DW'(16'h0100 + i), 1'b0);
      drive(2'b01, '0, 1'b0);
      for (int i = 0; i < 3; i++) drive(2'b01, '0, 1'b1);
      chk("t6 pre valid", rd_valid, 1);
      chk("t6 pre count", count, 5);
      fifo_command = 2'b00;
      MEM_READ     = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("t6 rst count", count, 0);
      chk("t6 rst valid", rd_valid, 0);
      chk("t6 rst err", err, 0);
      @(posedge clk);
      #4 reset = 1'b0;
      @(posedge clk);
      #1;
      drive(2'b10, 16'h00A1, 1'b0);
      drive(2'b10, 16'h00A2, 1'b0);
      chk("t6 count", count, 2);
      got.delete();
      drain_n(2);
      chk("t6 nwords", got.size(), 2);
      if (got.size() == 2) begin
         chk("t6 word0", got[0], 16'h00A1);
         chk("t6 word1", got[1], 16'h00A2);
      end
      chk("t6 err", err, 0);
      drive(2'b00, '0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_result_fifo.md
Name: conv_result_fifo

Overview:
Output result buffer directly downstream of the convolution controller and adder tree. It captures one adder-tree result per write command (fifo_command = 2'b10) issued at the end of each MEM_STORE pass. On the read command (2'b01, asserted when the frame is DONE), it drains the stored frame to the external reader under the MEM_READ handshake. It holds one full frame: 256 results.

Parameters:
DATA_WIDTH, 16, width of one convolution result word
DEPTH, 256, number of storage entries; must be a power of 2
ADDR_WIDTH, 8, log2(DEPTH); width of the read and write pointers

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset; clears all state
fifo_command  input  2  from controller: 00 idle, 10 write, 01 read/drain, 11 reserved (treated as 00)
wr_data  input  DATA_WIDTH  adder-tree result; sampled when a write is accepted
MEM_READ  input  1  external reader request, one word per high cycle
rd_data  output  DATA_WIDTH  drained word; valid only while rd_valid is high
rd_valid  output  1  one-cycle qualifier for rd_data
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  ADDR_WIDTH+1  number of stored words
drain_done  output  1  one-cycle pulse when the last word has been drained
err  output  2  sticky error flags: bit0 write dropped, bit1 read on empty or outside DRAIN

Behaviour:
- Reset (async, high): state=IDLE; wr_ptr=rd_ptr=0; count=0; empty=1; full=0; rd_valid=0; rd_data=0; drain_done=0; err=00. Reset mid-drain discards all stored data. Storage array contents are not reset.
- All other updates occur on the rising edge of clk. full and empty are decoded from registered count.
- FSM states: IDLE, DRAIN, HOLD.
- IDLE:
  - fifo_command==10 and !full: mem[wr_ptr]<=wr_data; wr_ptr increments (wraps DEPTH-1 -> 0); count increments.
  - fifo_command==10 and full: word dropped; err[0]<=1.
  - fifo_command==01: next state DRAIN. No write in that cycle.
  - A write command lasts one cycle and writes exactly one word. Back-to-back write cycles each write one word.
- DRAIN:
  - MEM_READ && !empty: rd_data<=mem[rd_ptr] and rd_valid<=1 on the next edge (latency 1 cycle); rd_ptr increments (wraps); count decrements.
  - MEM_READ && empty: no pointer change; rd_valid<=0; err[1]<=1.
  - fifo_command==10 in DRAIN: write ignored; err[0]<=1.
  - count reaches 0 after a read (or DRAIN entered with count==0): next state HOLD; drain_done pulses high for exactly one cycle, coincident with the rd_valid of the final word (or the cycle after DRAIN entry when empty).
- HOLD: the controller holds 01 after DONE, so the block stays in HOLD while fifo_command==01. This prevents repeated drains and repeated drain_done pulses. Any other command returns the FSM to IDLE. That command is not acted on in the same cycle.
- MEM_READ in IDLE or HOLD: ignored; rd_valid stays 0; err[1]<=1.
- rd_valid is 0 in any cycle not following an accepted read. rd_data holds its last value when rd_valid=0.
- Reads and writes are never concurrent (they are mode-exclusive), so count changes by at most ±1 per cycle.
- err bits are cleared only by reset.
- Code 11: no operation, no error.

Test Plan:
- Reset, then 4 single-cycle writes 0x0011, 0x0022, 0x0033, 0x0044 with gaps of 00 -> count=4, empty=0, full=0, err=00.
- From the previous state, command 01 held, MEM_READ high for 6 cycles -> rd_valid high for 4 cycles carrying 0x0011..0x0044 in order, one cycle after each accepted request. drain_done pulses once with 0x0044. err[1]=1 after the 5th request. State is HOLD.
- 256 consecutive writes of values 0..255, then a 257th write of 0xBEEF -> full=1, count=256, err[0]=1. The drain returns 0..255 exactly; 0xBEEF never appears.
- Pointer wrap: write 200 words, drain 200, return to IDLE via 00, write 100 words (values 1000+i), drain -> values 1000..1099 in order; count returns to 0.
- Command held at 01 for 20 cycles after drain_done -> no second drain_done pulse. Command 00 then 01 -> new DRAIN with empty FIFO and an immediate single drain_done pulse.
- Async reset asserted mid-drain, between clock edges, after 3 of 8 words -> outputs clear immediately (count=0, rd_valid=0, err=00). After release, state is IDLE and a new write/drain works.
